avalon_bus_arbiter: RTL and testbench
=====================================

// Module: avalon_bus_arbiter
// PURPOSE
//  Shares one Avalon-MM slave port (unified memory) between two Avalon-MM masters:
//  M0 (CPU bus port) and M1 (test loader / DMA). Registered grant FSM with round-robin
//  or fixed priority, per-master lock for back-to-back ownership. Sits between
//  mips_cpu_bus-style masters and the memory model in the testbench/top level.
// PARAMETERS
//  FIXED_PRIO  0  0 = round-robin between M0/M1; 1 = M0 always wins a contested arbitration
// PORTS
//  clk            in   1   clock, all state on rising edge
//  reset          in   1   synchronous, active-high
//  mN_read        in   1   master N read request (N = 0,1)
//  mN_write       in   1   master N write request
//  mN_lock        in   1   master N keeps the grant after its current transfer completes
//  mN_address     in   32  master N byte address
//  mN_byteenable  in   4   master N byte lanes
//  mN_writedata   in   32  master N write data
//  mN_waitrequest out  1   stall to master N
//  mN_readdata    out  32  read data to master N
//  s_read         out  1   slave read strobe
//  s_write        out  1   slave write strobe
//  s_address      out  32  slave address
//  s_byteenable   out  4   slave byte lanes
//  s_writedata    out  32  slave write data
//  s_waitrequest  in   1   slave stall
//  s_readdata     in   32  slave read data, valid in the cycle the read completes
//  grant          out  2   one-hot current owner {M1,M0}; 2'b00 = idle
// BEHAVIOUR
//  - reqN = mN_read | mN_write. Transfer by owner N completes in a cycle with reqN=1 and s_waitrequest=0.
//  - States: IDLE, OWN0, OWN1. Reset -> IDLE, rr pointer -> M0 preferred next; grant=00.
//  - IDLE: no req -> IDLE. One req -> OWN of that master. Both -> FIXED_PRIO ? OWN0 : master
//    indicated by rr pointer. Arbitration latency 1 cycle: requesting master sees waitrequest=1 in IDLE.
//  - OWNn: slave bus = mux of master n; s_read/s_write = mn_read/mn_write. mn_waitrequest = s_waitrequest.
//    On completion: mn_lock=1 -> stay OWNn; else rr pointer -> other master, then re-arbitrate in
//    same cycle as from IDLE (next state OWNother, OWNn, or IDLE). No idle bubble on switch.
//  - OWNn with reqn=0 (master withdrew, protocol violation) -> IDLE next cycle, no slave strobe issued.
//  - Non-owner requesting master: waitrequest=1 held, its signals ignored by slave.
//  - mN_readdata = s_readdata for both masters (broadcast); only owner's completion is meaningful.
//  - IDLE outputs: s_read=s_write=0, s_address/s_byteenable/s_writedata=0; m0/m1_waitrequest=1.
//  - Reset values: grant=00, s_read=s_write=0, s_address=0, s_byteenable=0, s_writedata=0,
//    m0_waitrequest=m1_waitrequest=1. Reset mid-transfer aborts immediately; no strobe next cycle.
//  - mN_read & mN_write both high: treated as write (s_write=1, s_read=0).
//  - Slave strobes change only on clock edges via state; all muxing from registered state, no
//    combinational path from mN_* request to grant.
//  - Lock never starves fairness checks: lock honoured only while lock and request stay high.
// TESTING
//  1. Reset, M0 read addr 0x1000, slave readdata 0xDEADBEEF, wait=0 -> grant 01 next cycle; M0 sees
//     waitrequest 1 then 0 with readdata 0xDEADBEEF; back to IDLE if no further req.
//  2. M0 and M1 request same cycle, FIXED_PRIO=0 -> M0 served first, M1 next with no idle cycle; repeat:
//     alternating grants 01,10,01,10.
//  3. FIXED_PRIO=1, both requesting continuously -> grant stays 01; M1 waitrequest held 1.
//  4. M1 write 0x0000_00FF to 0x2004, byteenable 0001, slave wait=1 for 3 cycles -> s_write held with
//     stable address/data 4 cycles; M1 waitrequest mirrors slave; M0 request stalls meanwhile.
//  5. M0 lock=1 across 3 reads with M1 requesting -> grant stays 01 for all 3; M1 granted after lock drops.
//  6. Reset asserted while OWN1 with s_waitrequest=1 -> next cycle grant 00, s_read=s_write=0, both waitrequest 1.

Source files
------------

// File: rtl/avalon_bus_arbiter_if.sv
// rtl/avalon_bus_arbiter_if.sv - Avalon-MM port bundle used on both arbiter sides
interface avalon_bus_arbiter_if;
  logic        read;
  logic        write;
  logic        lock;
  logic [31:0] address;
  logic [3:0]  byteenable;
  logic [31:0] writedata;
  logic        waitrequest;
  logic [31:0] readdata;

  modport master (
    output read, write, lock, address, byteenable, writedata,
    input  waitrequest, readdata
  );

  modport slave (
    input  read, write, lock, address, byteenable, writedata,
    output waitrequest, readdata
  );
endinterface

// File: rtl/avalon_bus_arbiter.sv
// rtl/avalon_bus_arbiter.sv - two-master Avalon-MM arbiter, registered grant, round-robin or fixed priority, lock
module avalon_bus_arbiter #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  avalon_bus_arbiter_if.slave  m0,
  avalon_bus_arbiter_if.slave  m1,
  avalon_bus_arbiter_if.master s,
  output logic [1:0]           grant
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   rr_m1;
  logic   rr_m1_nxt;
  logic   req0;
  logic   req1;

  assign req0 = m0.read | m0.write;
  assign req1 = m1.read | m1.write;

  // rr_m1 marks M1 as the preferred winner of the next contested arbitration.
  function automatic state_t arbitrate(input logic r0, input logic r1, input logic pref_m1);
    state_t pick;
    pick = IDLE;
    if (r0 && r1) begin
      pick = (FIXED_PRIO || !pref_m1) ? OWN0 : OWN1;
    end else if (r0) begin
      pick = OWN0;
    end else if (r1) begin
      pick = OWN1;
    end
    return pick;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      rr_m1 <= 1'b0;
    end else begin
      state <= state_nxt;
      rr_m1 <= rr_m1_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    rr_m1_nxt = rr_m1;
    unique case (state)
      IDLE: begin
        state_nxt = arbitrate(req0, req1, rr_m1);
      end
      OWN0: begin
        if (!req0) begin
          state_nxt = IDLE;
        end else if (!s.waitrequest && !m0.lock) begin
          rr_m1_nxt = 1'b1;
          state_nxt = arbitrate(req0, req1, 1'b1);
        end
      end
      OWN1: begin
        if (!req1) begin
          state_nxt = IDLE;
        end else if (!s.waitrequest && !m1.lock) begin
          rr_m1_nxt = 1'b0;
          state_nxt = arbitrate(req0, req1, 1'b0);
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Bus muxing keys off the registered owner only; a simultaneous read+write is issued as a write.
  always_comb begin
    s.read         = 1'b0;
    s.write        = 1'b0;
    s.lock         = 1'b0;
    s.address      = '0;
    s.byteenable   = '0;
    s.writedata    = '0;
    m0.waitrequest = 1'b1;
    m1.waitrequest = 1'b1;
    m0.readdata    = s.readdata;
    m1.readdata    = s.readdata;
    grant          = 2'b00;
    unique case (state)
      OWN0: begin
        s.read         = m0.read & ~m0.write;
        s.write        = m0.write;
        s.address      = m0.address;
        s.byteenable   = m0.byteenable;
        s.writedata    = m0.writedata;
        m0.waitrequest = s.waitrequest;
        grant          = 2'b01;
      end
      OWN1: begin
        s.read         = m1.read & ~m1.write;
        s.write        = m1.write;
        s.address      = m1.address;
        s.byteenable   = m1.byteenable;
        s.writedata    = m1.writedata;
        m1.waitrequest = s.waitrequest;
        grant          = 2'b10;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_avalon_bus_arbiter.sv
// tb/tb_avalon_bus_arbiter.sv - scoreboard bench for avalon_bus_arbiter with an ownership reference model
module tb_avalon_bus_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  avalon_bus_arbiter_if m0_if ();
  avalon_bus_arbiter_if m1_if ();
  avalon_bus_arbiter_if s_if ();
  avalon_bus_arbiter_if f0_if ();
  avalon_bus_arbiter_if f1_if ();
  avalon_bus_arbiter_if fs_if ();
  logic [1:0] grant;
  logic [1:0] grant_f;

  avalon_bus_arbiter #(.FIXED_PRIO(1'b0)) u_dut (
    .clk(clk), .reset(reset), .m0(m0_if), .m1(m1_if), .s(s_if), .grant(grant)
  );

  avalon_bus_arbiter #(.FIXED_PRIO(1'b1)) u_dut_fixed (
    .clk(clk), .reset(reset), .m0(f0_if), .m1(f1_if), .s(fs_if), .grant(grant_f)
  );

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
  } xfer_t;

  int n_checks = 0;
  int n_pass = 0;
  xfer_t exp_q0[$];
  xfer_t exp_q1[$];
  int done_q[$];
  int len_q[$];
  int owner = -1;
  int nxt_owner = -1;
  int pref = 0;
  bit model_ok = 1'b0;
  bit nxt_ok = 1'b0;
  int strobe_len = 0;
  int wait_pct = 0;
  bit wait_seq[$];
  bit fix_rd = 1'b0;
  logic [31:0] fix_val = 32'h0;
  logic [31:0] cur_rdata = 32'h0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  function automatic int winner(bit w0, bit w1, int p);
    if (w0 && w1) return p;
    if (w0) return 0;
    if (w1) return 1;
    return -1;
  endfunction

  task automatic drive_m(int n, logic rd, logic wr, logic lk, logic [31:0] a, logic [3:0] be, logic [31:0] d);
    if (n == 0) begin
      m0_if.read = rd; m0_if.write = wr; m0_if.lock = lk;
      m0_if.address = a; m0_if.byteenable = be; m0_if.writedata = d;
    end else begin
      m1_if.read = rd; m1_if.write = wr; m1_if.lock = lk;
      m1_if.address = a; m1_if.byteenable = be; m1_if.writedata = d;
    end
  endtask

  function automatic logic get_wait(int n);
    return (n == 0) ? m0_if.waitrequest : m1_if.waitrequest;
  endfunction

  // mode: 0 read, 1 write, 2 read+write (issued as a write)
  task automatic do_xfer(int n, int mode, logic [31:0] a, logic [3:0] be, logic [31:0] d, bit lk,
                         output int waits, output logic [31:0] rd);
    xfer_t e;
    bit done;
    e.wr = (mode != 0); e.addr = a; e.be = be; e.data = d;
    if (n == 0) exp_q0.push_back(e);
    else exp_q1.push_back(e);
    drive_m(n, mode != 1, mode != 0, lk, a, be, d);
    waits = 0; rd = 32'h0; done = 1'b0;
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge clk);
      if (!get_wait(n)) begin
        done = 1'b1;
        rd = (n == 0) ? m0_if.readdata : m1_if.readdata;
      end else begin
        waits++;
      end
    end
    if (!done) chk("xfer_done", 32'(done), 32'(1));
    @(posedge clk); #1;
    drive_m(n, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
  endtask

  task automatic rand_master(int n, int cnt);
    for (int i = 0; i < cnt; i++) begin
      int w;
      logic [31:0] rd;
      int gap;
      gap = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
      repeat (gap) begin @(posedge clk); #1; end
      do_xfer(n, int'($urandom_range(0, 2)), $urandom & 32'hFFFF_FFFC, 4'($urandom_range(1, 15)),
              $urandom, ($urandom_range(0, 3) == 0), w, rd);
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    wait_seq.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_grant", 32'(grant), 32'(2'b00));
    chk("rst_strobes", 32'({s_if.read, s_if.write}), 32'(2'b00));
    chk("rst_bus", s_if.address | s_if.writedata | 32'(s_if.byteenable), 32'h0);
    chk("rst_waits", 32'({m0_if.waitrequest, m1_if.waitrequest}), 32'(2'b11));
    @(posedge clk); #1;
  endtask

  function automatic int order_code();
    int code;
    code = 0;
    foreach (done_q[i]) code = code * 16 + done_q[i] + 1;
    return code;
  endfunction

  initial begin : slave_model
    s_if.waitrequest = 1'b1;
    s_if.readdata = 32'h0;
    forever begin
      @(posedge clk); #2;
      if (wait_seq.size() > 0) s_if.waitrequest = wait_seq.pop_front();
      else s_if.waitrequest = ($urandom_range(0, 99) < wait_pct);
      cur_rdata = fix_rd ? fix_val : $urandom;
      s_if.readdata = cur_rdata;
    end
  end

  // Ownership model: who may drive the slave this cycle, and who owns it next.
  initial begin : monitor
    xfer_t e;
    logic r0, r1, lk, ex_rd, ex_wr, ex_w0, ex_w1, strobe;
    logic [1:0] ex_g;
    logic [31:0] ex_a, ex_d;
    logic [3:0] ex_be;
    forever begin
      @(negedge clk);
      owner = nxt_owner;
      model_ok = nxt_ok;
      r0 = m0_if.read | m0_if.write;
      r1 = m1_if.read | m1_if.write;
      lk = (owner == 0) ? m0_if.lock : m1_if.lock;
      if (model_ok) begin
        ex_g = 2'b00; ex_rd = 1'b0; ex_wr = 1'b0; ex_a = 32'h0; ex_d = 32'h0; ex_be = 4'h0;
        ex_w0 = 1'b1; ex_w1 = 1'b1;
        if (owner == 0) begin
          ex_g = 2'b01; ex_wr = m0_if.write; ex_rd = m0_if.read && !m0_if.write;
          ex_a = m0_if.address; ex_d = m0_if.writedata; ex_be = m0_if.byteenable;
          ex_w0 = s_if.waitrequest;
        end else if (owner == 1) begin
          ex_g = 2'b10; ex_wr = m1_if.write; ex_rd = m1_if.read && !m1_if.write;
          ex_a = m1_if.address; ex_d = m1_if.writedata; ex_be = m1_if.byteenable;
          ex_w1 = s_if.waitrequest;
        end
        chk("grant", 32'(grant), 32'(ex_g));
        chk("s_read", 32'(s_if.read), 32'(ex_rd));
        chk("s_write", 32'(s_if.write), 32'(ex_wr));
        chk("s_address", s_if.address, ex_a);
        chk("s_byteenable", 32'(s_if.byteenable), 32'(ex_be));
        chk("s_writedata", s_if.writedata, ex_d);
        chk("m0_waitrequest", 32'(m0_if.waitrequest), 32'(ex_w0));
        chk("m1_waitrequest", 32'(m1_if.waitrequest), 32'(ex_w1));
        chk("m0_readdata", m0_if.readdata, cur_rdata);
        chk("m1_readdata", m1_if.readdata, cur_rdata);
        strobe = s_if.read | s_if.write;
        strobe_len = strobe ? strobe_len + 1 : 0;
        if (owner >= 0 && ((owner == 0) ? r0 : r1) && !s_if.waitrequest && !reset) begin
          chk("sb_pending", 32'(((owner == 0) ? exp_q0.size() : exp_q1.size()) > 0), 32'(1));
          if (((owner == 0) ? exp_q0.size() : exp_q1.size()) > 0) begin
            e = (owner == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            chk("sb_write", 32'(s_if.write), 32'(e.wr));
            chk("sb_address", s_if.address, e.addr);
            chk("sb_byteenable", 32'(s_if.byteenable), 32'(e.be));
            if (e.wr) chk("sb_writedata", s_if.writedata, e.data);
          end
          done_q.push_back(owner);
          len_q.push_back(strobe_len);
          strobe_len = 0;
        end
      end
      if (reset) begin
        nxt_owner = -1; pref = 0; nxt_ok = 1'b1;
      end else if (model_ok) begin
        if (owner < 0) nxt_owner = winner(r0, r1, pref);
        else if (!((owner == 0) ? r0 : r1)) nxt_owner = -1;
        else if (s_if.waitrequest || lk) nxt_owner = owner;
        else begin
          pref = 1 - owner;
          nxt_owner = winner(r0, r1, pref);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    int w;
    logic [31:0] rd;
    drive_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    drive_m(1, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    f0_if.read = 1'b0; f0_if.write = 1'b0; f0_if.lock = 1'b0;
    f0_if.address = 32'h0; f0_if.byteenable = 4'h0; f0_if.writedata = 32'h0;
    f1_if.read = 1'b0; f1_if.write = 1'b0; f1_if.lock = 1'b0;
    f1_if.address = 32'h0; f1_if.byteenable = 4'h0; f1_if.writedata = 32'h0;
    fs_if.waitrequest = 1'b0; fs_if.readdata = 32'h0;

    apply_reset();
    fix_rd = 1'b1; fix_val = 32'hDEAD_BEEF;
    do_xfer(0, 0, 32'h0000_1000, 4'hF, 32'h0, 1'b0, w, rd);
    chk("t1_waits", 32'(w), 32'(1));
    chk("t1_readdata", rd, 32'hDEAD_BEEF);
    repeat (2) @(negedge clk);
    chk("t1_idle_grant", 32'(grant), 32'(2'b00));
    fix_rd = 1'b0;
    @(posedge clk); #1;

    apply_reset();
    done_q.delete();
    fork
      begin
        do_xfer(0, 0, 32'h100, 4'hF, 32'h0, 1'b0, w, rd);
        do_xfer(0, 0, 32'h104, 4'hF, 32'h0, 1'b0, w, rd);
      end
      begin
        do_xfer(1, 0, 32'h200, 4'hF, 32'h0, 1'b0, w, rd);
        do_xfer(1, 0, 32'h204, 4'hF, 32'h0, 1'b0, w, rd);
      end
    join
    chk("t2_order", 32'(order_code()), 32'h1212);

    f0_if.read = 1'b1; f1_if.read = 1'b1;
    @(negedge clk);
    chk("t3_first_idle", 32'(grant_f), 32'(2'b00));
    repeat (6) begin
      @(negedge clk);
      chk("t3_grant_fixed", 32'(grant_f), 32'(2'b01));
      chk("t3_m1_wait", 32'(f1_if.waitrequest), 32'(1));
    end
    @(posedge clk); #1;
    f0_if.read = 1'b0; f1_if.read = 1'b0;

    apply_reset();
    done_q.delete(); len_q.delete();
    wait_seq = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    fork
      do_xfer(1, 1, 32'h0000_2004, 4'b0001, 32'h0000_00FF, 1'b0, w, rd);
      begin
        @(posedge clk); #1;
        do_xfer(0, 0, 32'h0000_3000, 4'hF, 32'h0, 1'b0, w, rd);
      end
    join
    chk("t4_order", 32'(order_code()), 32'h21);
    chk("t4_write_len", 32'((len_q.size() > 0) ? len_q[0] : 0), 32'(4));

    apply_reset();
    done_q.delete();
    fork
      begin
        do_xfer(0, 0, 32'h10, 4'hF, 32'h0, 1'b1, w, rd);
        do_xfer(0, 0, 32'h14, 4'hF, 32'h0, 1'b1, w, rd);
        do_xfer(0, 0, 32'h18, 4'hF, 32'h0, 1'b0, w, rd);
      end
      begin
        @(posedge clk); #1;
        do_xfer(1, 1, 32'h20, 4'hF, 32'h1234_5678, 1'b0, w, rd);
      end
    join
    chk("t5_order", 32'(order_code()), 32'h1112);

    apply_reset();
    for (int i = 0; i < 10; i++) wait_seq.push_back(1'b1);
    drive_m(1, 1'b0, 1'b1, 1'b0, 32'h44, 4'hF, 32'h55);
    repeat (2) @(negedge clk);
    chk("t6_owned", 32'(grant), 32'(2'b10));
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    drive_m(1, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    @(negedge clk);
    chk("t6_grant", 32'(grant), 32'(2'b00));
    chk("t6_strobes", 32'({s_if.read, s_if.write}), 32'(2'b00));
    chk("t6_waits", 32'({m0_if.waitrequest, m1_if.waitrequest}), 32'(2'b11));
    wait_seq.delete();
    @(posedge clk); #1;

    apply_reset();
    wait_pct = 30;
    fork
      rand_master(0, 60);
      rand_master(1, 60);
    join
    repeat (3) @(posedge clk);
    #1;
    chk("sb_q0_drained", 32'(exp_q0.size()), 32'(0));
    chk("sb_q1_drained", 32'(exp_q1.size()), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
